// File: rtl/galvo_pkg.sv
// Shared constants, state type and DAC word builder for the galvo raster writer.
package galvo_pkg;

  localparam int unsigned FRAME_W = 24;  // bits per DAC SPI frame
  localparam int unsigned POS_W   = 11;  // raster position width
  localparam int unsigned ADDR_W  = 4;   // DAC channel address field
  localparam int unsigned CMD_W   = 4;   // DAC command field
  localparam int unsigned PAD_W   = 5;   // zero pad below the position

  localparam logic [ADDR_W-1:0] ADDR_H = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_V = 4'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FRAME_H,
    ST_GAP_H,
    ST_FRAME_V,
    ST_GAP_V,
    ST_SETTLE,
    ST_DONE
  } state_t;

  // {cmd, addr, pos, pad}: position is left-justified in the 16-bit data field.
  function automatic logic [FRAME_W-1:0] make_word(input logic [CMD_W-1:0]  cmd,
                                                   input logic [ADDR_W-1:0] addr,
                                                   input logic [POS_W-1:0]  pos);
    make_word = {cmd, addr, pos, {PAD_W{1'b0}}};
  endfunction

endpackage

// File: rtl/spi_tx24.sv
// 24-bit mode-0 SPI shifter with SCLK divider.
//   clk_adc, rst_adc : clock, synchronous active-high reset
//   start, data      : launch a frame of data (MSB first) when idle
//   abort            : drop any frame in flight, return lines to idle
//   csn, sclk, mosi  : registered SPI lines
//   busy             : high while a frame is being shifted
module spi_tx24
  import galvo_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic               clk_adc,
  input  logic               rst_adc,
  input  logic               start,
  input  logic               abort,
  input  logic [FRAME_W-1:0] data,
  output logic               csn,
  output logic               sclk,
  output logic               mosi,
  output logic               busy
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(FRAME_W);

  logic [DIV_W-1:0]   div_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [FRAME_W-2:0] shreg;   // bits still to send after the one on mosi

  // Each bit: CLK_DIV cycles SCLK low, then CLK_DIV cycles high; mosi only moves on the fall.
  always_ff @(posedge clk_adc) begin
    if (rst_adc || abort) begin
      csn     <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (!busy) begin
      if (start) begin
        csn     <= 1'b0;
        sclk    <= 1'b0;
        mosi    <= data[FRAME_W-1];
        busy    <= 1'b1;
        div_cnt <= '0;
        bit_cnt <= '0;
        shreg   <= data[FRAME_W-2:0];
      end
    end else if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
      div_cnt <= '0;
      if (!sclk) begin
        sclk <= 1'b1;
      end else begin
        sclk <= 1'b0;
        if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
          csn  <= 1'b1;
          mosi <= 1'b0;
          busy <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + BIT_W'(1);
          mosi    <= shreg[FRAME_W-2];
          shreg   <= {shreg[FRAME_W-3:0], 1'b0};
        end
      end
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/galvo_scan.sv
// Galvo raster generator: writes H then V position to the DAC, settles, commits and advances.
//   clk_adc, rst_adc       : clock, synchronous active-high reset
//   step, restart          : advance-one-point request, abort to raster origin
//   h_max, v_max           : last horizontal / vertical index
//   serpentine             : 1 = boustrophedon rows, 0 = flyback
//   settle                 : post-write settle cycles
//   galvoh, galvov         : last committed position
//   galvo_spi_done         : point written and settled (one cycle)
//   frame_done             : last point of the frame (with galvo_spi_done)
//   busy, overrun          : not idle; sticky dropped-step flag
//   spi_csn/sclk/mosi      : DAC serial port
module galvo_scan
  import galvo_pkg::*;
#(
  parameter int unsigned       CLK_DIV = 4,
  parameter logic [CMD_W-1:0]  CMD     = 4'b0011
) (
  input  logic             clk_adc,
  input  logic             rst_adc,
  input  logic             step,
  input  logic             restart,
  input  logic [POS_W-1:0] h_max,
  input  logic [POS_W-1:0] v_max,
  input  logic             serpentine,
  input  logic [15:0]      settle,
  output logic [POS_W-1:0] galvoh,
  output logic [POS_W-1:0] galvov,
  output logic             galvo_spi_done,
  output logic             frame_done,
  output logic             busy,
  output logic             overrun,
  output logic             spi_csn,
  output logic             spi_sclk,
  output logic             spi_mosi
);

  localparam int unsigned GAP_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  // The FRAME state already spends one gap cycle noticing the shifter went idle.
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((CLK_DIV > 1) ? (CLK_DIV - 2) : 0);

  state_t            state, state_nxt;
  logic [POS_W-1:0]  h, h_nxt, v, v_nxt;
  logic              rev, rev_nxt;
  logic              pending, pend_nxt;
  logic              ovr_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;
  logic [15:0]       settle_cnt, settle_nxt;
  logic [POS_W-1:0]  galvoh_nxt, galvov_nxt;
  logic              done_nxt, fd_nxt, busy_nxt;

  logic              tx_start_c, tx_abort_c, tx_busy;
  logic [FRAME_W-1:0] tx_data_c;
  logic              post_v_c, enter_done_c, row_end_c, frame_end_c;

  spi_tx24 #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk_adc (clk_adc),
    .rst_adc (rst_adc),
    .start   (tx_start_c),
    .abort   (tx_abort_c),
    .data    (tx_data_c),
    .csn     (spi_csn),
    .sclk    (spi_sclk),
    .mosi    (spi_mosi),
    .busy    (tx_busy)
  );

  // State and registered outputs.
  always_ff @(posedge clk_adc) begin
    if (rst_adc) begin
      state          <= ST_IDLE;
      h              <= '0;
      v              <= '0;
      rev            <= 1'b0;
      pending        <= 1'b0;
      overrun        <= 1'b0;
      gap_cnt        <= '0;
      settle_cnt     <= '0;
      galvoh         <= '0;
      galvov         <= '0;
      galvo_spi_done <= 1'b0;
      frame_done     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nxt;
      h              <= h_nxt;
      v              <= v_nxt;
      rev            <= rev_nxt;
      pending        <= pend_nxt;
      overrun        <= ovr_nxt;
      gap_cnt        <= gap_nxt;
      settle_cnt     <= settle_nxt;
      galvoh         <= galvoh_nxt;
      galvov         <= galvov_nxt;
      galvo_spi_done <= done_nxt;
      frame_done     <= fd_nxt;
      busy           <= busy_nxt;
    end
  end

  // Sequencing, step bookkeeping and raster advance.
  always_comb begin
    state_nxt    = state;
    h_nxt        = h;
    v_nxt        = v;
    rev_nxt      = rev;
    pend_nxt     = pending;
    ovr_nxt      = overrun;
    gap_nxt      = gap_cnt;
    settle_nxt   = settle_cnt;
    galvoh_nxt   = galvoh;
    galvov_nxt   = galvov;
    done_nxt     = 1'b0;
    fd_nxt       = 1'b0;
    tx_start_c   = 1'b0;
    tx_abort_c   = 1'b0;
    tx_data_c    = make_word(CMD, ADDR_H, h);
    post_v_c     = 1'b0;
    enter_done_c = 1'b0;

    // >= on forward rows lets a shrinking h_max end the row immediately.
    row_end_c   = rev ? (h == '0) : (h >= h_max);
    frame_end_c = row_end_c && (v >= v_max);

    if (restart) begin
      state_nxt  = ST_IDLE;
      h_nxt      = '0;
      v_nxt      = '0;
      rev_nxt    = 1'b0;
      pend_nxt   = 1'b0;
      ovr_nxt    = 1'b0;
      tx_abort_c = 1'b1;
    end else begin
      if (step && (state != ST_IDLE) && (state != ST_DONE)) begin
        if (pending) ovr_nxt  = 1'b1;
        else         pend_nxt = 1'b1;
      end

      unique case (state)
        ST_IDLE: begin
          if (step) begin
            tx_start_c = 1'b1;
            state_nxt  = ST_FRAME_H;
          end
        end
        ST_FRAME_H: begin
          if (!tx_busy) begin
            if (CLK_DIV == 1) begin
              tx_start_c = 1'b1;
              tx_data_c  = make_word(CMD, ADDR_V, v);
              state_nxt  = ST_FRAME_V;
            end else begin
              gap_nxt   = GAP_LOAD;
              state_nxt = ST_GAP_H;
            end
          end
        end
        ST_GAP_H: begin
          if (gap_cnt == '0) begin
            tx_start_c = 1'b1;
            tx_data_c  = make_word(CMD, ADDR_V, v);
            state_nxt  = ST_FRAME_V;
          end else begin
            gap_nxt = gap_cnt - GAP_W'(1);
          end
        end
        ST_FRAME_V: begin
          if (!tx_busy) begin
            if (CLK_DIV == 1) begin
              post_v_c = 1'b1;
            end else begin
              gap_nxt   = GAP_LOAD;
              state_nxt = ST_GAP_V;
            end
          end
        end
        ST_GAP_V: begin
          if (gap_cnt == '0) post_v_c = 1'b1;
          else               gap_nxt  = gap_cnt - GAP_W'(1);
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) enter_done_c = 1'b1;
          else                  settle_nxt   = settle_cnt - 16'd1;
        end
        ST_DONE: begin
          // A step landing in DONE is treated as already pending.
          if (pending || step) begin
            tx_start_c = 1'b1;
            pend_nxt   = pending && step;
            state_nxt  = ST_FRAME_H;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase

      // settle is sampled here, on entry to SETTLE.
      if (post_v_c) begin
        if (settle == 16'd0) begin
          enter_done_c = 1'b1;
        end else begin
          settle_nxt = settle - 16'd1;
          state_nxt  = ST_SETTLE;
        end
      end

      // Commit the point just written and move the raster on.
      if (enter_done_c) begin
        state_nxt  = ST_DONE;
        done_nxt   = 1'b1;
        fd_nxt     = frame_end_c;
        galvoh_nxt = h;
        galvov_nxt = v;
        if (frame_end_c) begin
          h_nxt   = '0;
          v_nxt   = '0;
          rev_nxt = 1'b0;
        end else if (row_end_c) begin
          v_nxt = v + POS_W'(1);
          if (serpentine) rev_nxt = ~rev;
          else            h_nxt   = '0;
        end else begin
          h_nxt = rev ? (h - POS_W'(1)) : (h + POS_W'(1));
        end
      end
    end

    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule

// File: tb/tb_galvo_scan.sv
// Directed self-checking bench for galvo_scan (CLK_DIV = 4).
module tb_galvo_scan;

  localparam int unsigned D = 4;

  logic        clk_adc = 1'b0;
  logic        rst_adc = 1'b1;
  logic        step = 1'b0;
  logic        restart = 1'b0;
  logic [10:0] h_max = 11'd2;
  logic [10:0] v_max = 11'd1;
  logic        serpentine = 1'b0;
  logic [15:0] settle = 16'd0;
  logic [10:0] galvoh, galvov;
  logic        galvo_spi_done, frame_done, busy, overrun;
  logic        spi_csn, spi_sclk, spi_mosi;

  int checks = 0;
  int failures = 0;

  logic [23:0] words[$];
  logic [23:0] sh = '0;
  int          nb = 0;

  galvo_scan #(.CLK_DIV(D), .CMD(4'b0011)) dut (
    .clk_adc        (clk_adc),
    .rst_adc        (rst_adc),
    .step           (step),
    .restart        (restart),
    .h_max          (h_max),
    .v_max          (v_max),
    .serpentine     (serpentine),
    .settle         (settle),
    .galvoh         (galvoh),
    .galvov         (galvov),
    .galvo_spi_done (galvo_spi_done),
    .frame_done     (frame_done),
    .busy           (busy),
    .overrun        (overrun),
    .spi_csn        (spi_csn),
    .spi_sclk       (spi_sclk),
    .spi_mosi       (spi_mosi)
  );

  always #5 clk_adc = ~clk_adc;

  // DAC-side receiver: mode 0, sample MOSI on SCLK rise; CSN high discards partial frames.
  always @(posedge spi_sclk or posedge spi_csn) begin
    if (spi_csn) begin
      nb = 0;
    end else begin
      sh = {sh[22:0], spi_mosi};
      nb++;
      if (nb == 24) begin
        words.push_back(sh);
        nb = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_adc);
    #1;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  // One step from idle; checks latency, committed point, frame_done and both DAC words.
  task automatic run_step(input logic [10:0] eh, input logic [10:0] ev, input logic efd);
    int n;
    int base;
    base = words.size();
    step = 1'b1;
    tick();
    step = 1'b0;
    n = 1;
    while (!galvo_spi_done && n < 5000) begin
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'(98 * D + 32'(settle) + 1));
    chk("galvoh", 32'(galvoh), 32'(eh));
    chk("galvov", 32'(galvov), 32'(ev));
    chk("frame_done", 32'(frame_done), 32'(efd));
    chk("nwords", 32'(words.size() - base), 32'd2);
    if (words.size() - base == 2) begin
      chk("word_h", 32'(words[base]),     32'({4'h3, 4'h0, eh, 5'b0}));
      chk("word_v", 32'(words[base + 1]), 32'({4'h3, 4'h1, ev, 5'b0}));
    end
    tick();
  endtask

  initial begin
    int first;
    int second;
    int dcnt;

    repeat (3) tick();
    rst_adc = 1'b0;

    // Reset state
    chk("rst_csn", 32'(spi_csn), 32'd1);
    chk("rst_sclk", 32'(spi_sclk), 32'd0);
    chk("rst_mosi", 32'(spi_mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(galvo_spi_done), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_gh", 32'(galvoh), 32'd0);

    // Flyback raster: first point doubles as the single-step latency/word test
    run_step(11'd0, 11'd0, 1'b0);
    run_step(11'd1, 11'd0, 1'b0);
    run_step(11'd2, 11'd0, 1'b0);
    run_step(11'd0, 11'd1, 1'b0);
    run_step(11'd1, 11'd1, 1'b0);
    run_step(11'd2, 11'd1, 1'b1);
    run_step(11'd0, 11'd0, 1'b0);

    // Serpentine raster
    do_restart();
    serpentine = 1'b1;
    run_step(11'd0, 11'd0, 1'b0);
    run_step(11'd1, 11'd0, 1'b0);
    run_step(11'd2, 11'd0, 1'b0);
    run_step(11'd2, 11'd1, 1'b0);
    run_step(11'd1, 11'd1, 1'b0);
    run_step(11'd0, 11'd1, 1'b1);

    // Pending and overrun: steps at cycles 0, 10, 20
    do_restart();
    serpentine = 1'b0;
    first = 0;
    second = 0;
    dcnt = 0;
    step = 1'b1;
    tick();
    for (int c = 1; c <= 800; c++) begin
      if (c == 1)   chk("csn_h_low", 32'(spi_csn), 32'd0);
      if (c == 1)   chk("busy_c1", 32'(busy), 32'd1);
      if (c == 193) chk("csn_gap_h", 32'(spi_csn), 32'd1);
      if (c == 196) chk("csn_gap_end", 32'(spi_csn), 32'd1);
      if (c == 197) chk("csn_v_low", 32'(spi_csn), 32'd0);
      if (c == 394) chk("csn_b2b", 32'(spi_csn), 32'd0);
      if (galvo_spi_done) begin
        dcnt++;
        if (first == 0) first = c;
        else if (second == 0) second = c;
      end
      step = (c == 10 || c == 20);
      tick();
    end
    step = 1'b0;
    chk("pend_count", 32'(dcnt), 32'd2);
    chk("pend_first", 32'(first), 32'd393);
    chk("pend_second", 32'(second), 32'd786);
    chk("overrun", 32'(overrun), 32'd1);
    chk("pend_gh", 32'(galvoh), 32'd1);

    // Restart mid-frame at cycle 100
    do_restart();
    chk("ovr_clear", 32'(overrun), 32'd0);
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (99) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rs_csn", 32'(spi_csn), 32'd1);
    chk("rs_sclk", 32'(spi_sclk), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    dcnt = 0;
    for (int c = 0; c < 400; c++) begin
      if (galvo_spi_done) dcnt++;
      tick();
    end
    chk("rs_no_done", 32'(dcnt), 32'd0);
    chk("rs_keep_gh", 32'(galvoh), 32'd1);
    run_step(11'd0, 11'd0, 1'b0);

    // Settle = 1000, then reset mid-write
    settle = 16'd1000;
    run_step(11'd1, 11'd0, 1'b0);
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (49) tick();
    rst_adc = 1'b1;
    tick();
    chk("mr_csn", 32'(spi_csn), 32'd1);
    chk("mr_sclk", 32'(spi_sclk), 32'd0);
    chk("mr_mosi", 32'(spi_mosi), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_done", 32'(galvo_spi_done), 32'd0);
    chk("mr_fd", 32'(frame_done), 32'd0);
    chk("mr_ovr", 32'(overrun), 32'd0);
    chk("mr_gh", 32'(galvoh), 32'd0);
    chk("mr_gv", 32'(galvov), 32'd0);
    rst_adc = 1'b0;
    tick();

    // h_max = 0: h pinned at 0 in serpentine
    settle = 16'd0;
    h_max = 11'd0;
    serpentine = 1'b1;
    run_step(11'd0, 11'd0, 1'b0);
    run_step(11'd0, 11'd1, 1'b1);
    run_step(11'd0, 11'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
